csa_resolver: RTL and testbench
===============================

CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits resolved per cycle; WIDTH % CHUNK == 0, CHUNK >= 1.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: a carry-save pair is presented.
REQ-006 SHALL have port in_ready  output  1: the block accepts a pair this cycle.
REQ-007 SHALL have port in_sum  input  WIDTH: sum vector (full-adder Y outputs, weight 2^i).
REQ-008 SHALL have port in_carry  input  WIDTH: carry vector (full-adder X outputs, bit i weight 2^(i+1)).
REQ-009 SHALL have port out_valid  output  1: out_result holds a resolved value.
REQ-010 SHALL have port out_ready  input  1: consumer takes the result.
REQ-011 SHALL have port out_result  output  WIDTH+2: binary value in_sum + 2*in_carry.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid && in_ready.
REQ-014 SHALL, on transfer, latch in_sum and {in_carry[WIDTH-2:0],1'b0} into operand registers, latch in_carry[WIDTH-1] as top carry, clear chunk index and carry-in, and go to RUN.
REQ-015 SHALL in RUN, each cycle, add CHUNK bits of both operands at the chunk index plus carry-in, write result bits [idx*CHUNK +: CHUNK], register the chunk carry-out as next carry-in, and increment the index.
REQ-016 SHALL on the last chunk (idx == WIDTH/CHUNK-1) also write out_result[WIDTH+1:WIDTH] = top carry + chunk carry-out (2-bit add), then go to DONE.
REQ-017 SHALL assert out_valid only in DONE; out_valid to out_result are held stable until out_ready.
REQ-018 SHALL go DONE -> IDLE when out_ready; out_valid falls next cycle.
REQ-019 SHALL give latency WIDTH/CHUNK cycles from transfer edge to out_valid high; throughput one result per WIDTH/CHUNK+2 cycles with out_ready tied high.
REQ-020 SHALL ignore in_valid and input data outside IDLE.
REQ-021 SHALL be exact for all inputs: max value 3*(2^WIDTH-1) fits WIDTH+2 bits without truncation.
REQ-022 SHALL handle CHUNK == WIDTH: RUN lasts one cycle.

Reset
REQ-023 SHALL on reset enter IDLE, drive in_ready=1 after reset deasserts, out_valid=0, out_result=0, clear index, carry-in, and operand registers.
REQ-024 SHALL on reset asserted in RUN or DONE abandon the operation with no partial result ever marked valid.
REQ-025 SHALL give reset priority over any simultaneous handshake.

Configuration
REQ-026 SHALL, with CSA_RESOLVER_BYPASS_EN defined, on transfer with in_carry == 0, skip RUN: load out_result = {2'b00,in_sum} and enter DONE next cycle (latency 1).
REQ-027 SHALL, without CSA_RESOLVER_BYPASS_EN, always traverse RUN per REQ-015; bypass logic absent from netlist.

Structure
REQ-028 SHALL place the FSM state enum and the CHUNK-count constant function in shared package csa_resolver_pkg.
REQ-029 SHALL implement per-cycle chunk add in one sub-module csa_chunk_add (CHUNK-bit operands, carry-in, sum, carry-out), the only combinational adder instance.

Verification (WIDTH=8, CHUNK=4, bypass off unless noted)
REQ-030 SHALL test in_sum=0xFF, in_carry=0xFF -> out_result=0x2FD, out_valid 2 cycles after transfer.
REQ-031 SHALL test in_sum=0x0F, in_carry=0x08 -> 0x01F; chunk-boundary carry 0x0F+0x10: in_sum=0x0F,in_carry=0x08 sanity, then in_sum=0x0F,in_carry=0x01 -> 0x011.
REQ-032 SHALL test out_ready held low 5 cycles after in_sum=0x01,in_carry=0x80 -> out_result=0x101 held stable, in_ready low, second in_valid ignored.
REQ-033 SHALL test reset pulsed during RUN -> out_valid stays 0, IDLE with in_ready=1 next cycle, next op 0x03/0x01 -> 0x005.
REQ-034 SHALL test with CSA_RESOLVER_BYPASS_EN: in_sum=0xA5, in_carry=0x00 -> 0x0A5 with out_valid 1 cycle after transfer.
REQ-035 SHALL test 1000 random back-to-back ops against golden in_sum+2*in_carry with random out_ready stalls.

Source files
------------

// File: rtl/csa_resolver_pkg.sv
// rtl/csa_resolver_pkg.sv - shared FSM state type and chunk-count helper for csa_resolver
package csa_resolver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// rtl/csa_chunk_add.sv - CHUNK-bit ripple slice with carry-in/carry-out
module csa_chunk_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - resolves a carry-save pair to binary, CHUNK bits per cycle
// Optional CSA_RESOLVER_BYPASS_EN: pairs with a zero carry vector skip RUN.
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_result
);

  localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             top_carry;
  logic [IDX_W-1:0] idx;
  logic             cin;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IDX_W'(k)) begin
        a_chunk = op_a[k*CHUNK +: CHUNK];
        b_chunk = op_b[k*CHUNK +: CHUNK];
      end
    end
  end

  csa_chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (cin),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      op_a       <= '0;
      op_b       <= '0;
      top_carry  <= 1'b0;
      idx        <= '0;
      cin        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // carry bit i weighs 2^(i+1); its MSB overflows into the top result bits
            op_a      <= in_sum;
            op_b      <= {in_carry[WIDTH-2:0], 1'b0};
            top_carry <= in_carry[WIDTH-1];
            idx       <= '0;
            cin       <= 1'b0;
            in_ready  <= 1'b0;
`ifdef CSA_RESOLVER_BYPASS_EN
            if (in_carry == '0) begin
              out_result <= {2'b00, in_sum};
              out_valid  <= 1'b1;
              state      <= DONE;
            end else
`endif
            begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) out_result[k*CHUNK +: CHUNK] <= chunk_sum;
          end
          cin <= chunk_cout;
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            out_result[WIDTH+1:WIDTH] <= {1'b0, top_carry} + {1'b0, chunk_cout};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolver.sv
// tb/tb_csa_resolver.sv - scoreboard bench for csa_resolver (WIDTH=8, CHUNK=4)
module tb_csa_resolver;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] out_result;

  int checks = 0;
  int fails  = 0;
  bit ready_mode = 1'b0;
  logic [W+1:0] exp_q[$];

  csa_resolver #(.WIDTH(W), .CHUNK(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W+1:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
    int v;
    v = int'(s) + 2 * int'(c);
    return v[W+1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
    int guard;
    guard = 0;
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        checks++;
        fails++;
        $display("FAIL send_timeout: in_ready never rose, got 0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(model(s, c));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) break;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (ready_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  bit           hold = 1'b0;
  logic [W+1:0] held_val;

  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        if (out_valid) check("hold_result", 32'(out_result), 32'(held_val));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got 0x%0h expected no output", out_result);
        end else begin
          check("result", 32'(out_result), 32'(exp_q.pop_front()));
        end
      end
      hold = out_valid && !out_ready;
      held_val = out_result;
    end
  end

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_result", 32'(out_result), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);

    // full-scale operands and chunk-boundary carries
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'hFF, 8'hFF);
    wait_valid(lat);
    check("latency_ff_ff", 32'(lat), 32'd2);
    check("value_ff_ff", 32'(out_result), 32'h2FD);
    send(8'h0F, 8'h08);
    wait_valid(lat);
    send(8'h0F, 8'h01);
    wait_valid(lat);
    check("value_0f_01", 32'(out_result), 32'h011);

    // consumer stall with a stray request that must be ignored
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(8'h01, 8'h80);
    wait_valid(lat);
    check("latency_01_80", 32'(lat), 32'd2);
    in_sum   = 8'h55;
    in_carry = 8'h55;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_result", 32'(out_result), 32'h101);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("no_stray_output", 32'(out_valid), 32'd0);
    end

    // reset in the middle of RUN abandons the operation
    @(posedge clk);
    #1;
    send(8'h12, 8'h34);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'h03, 8'h01);
    wait_valid(lat);
    check("value_03_01", 32'(out_result), 32'h005);

`ifdef CSA_RESOLVER_BYPASS_EN
    send(8'hA5, 8'h00);
    wait_valid(lat);
    check("bypass_latency", 32'(lat), 32'd1);
    check("bypass_value", 32'(out_result), 32'h0A5);
`endif

    // randomized back-to-back traffic with consumer stalls
    @(posedge clk);
    #1 ready_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send(W'($urandom), W'($urandom));
    end

    ready_mode = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
